dual_port_ram_clr: RTL and testbench
====================================

// Module: dual_port_ram_clr
// PURPOSE
//  Parametrised true dual-port RAM: two independent read/write ports on one clock.
//  Read mode is selectable: asynchronous (combinational) or registered.
//  Adds a hardware clear sequencer that zero-fills the array after reset or on request.
//  Adds deterministic same-address write-collision resolution with a collision flag.
//  Drop-in successor to the fixed 16x8 dual-port async-read RAM in the memory library.
// PARAMETERS
//  DATA_W    8  word width in bits (>=1)
//  ADDR_W    4  address width; DEPTH = 2**ADDR_W words
//  READ_REG  0  0: async read (dout follows addr combinationally); 1: registered read, 1-cycle latency
//  B_WINS    0  collision priority: 0 = port A data stored, 1 = port B data stored
// PORTS
//  clk     in   1       single clock, all state updates on posedge
//  rst     in   1       asynchronous, active-high reset
//  clr     in   1       synchronous single-cycle pulse: start array zero-fill (ignored while busy)
//  we_a    in   1       port A write enable
//  addr_a  in   ADDR_W  port A address
//  din_a   in   DATA_W  port A write data
//  dout_a  out  DATA_W  port A read data
//  we_b    in   1       port B write enable
//  addr_b  in   ADDR_W  port B address
//  din_b   in   DATA_W  port B write data
//  dout_b  out  DATA_W  port B read data
//  busy    out  1       high during reset and during clear sweep
//  collide out  1       registered 1-cycle pulse: both ports wrote the same address last edge
// BEHAVIOUR
//  Reset (rst=1, async): FSM->CLEAR, clr_ptr=0, busy=1, collide=0, registered douts=0.
//   Memory contents are not reset directly; the sweep zeroes them.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each edge writes 0 to mem[clr_ptr], clr_ptr++.
//   At clr_ptr==DEPTH-1, that last word is written, then ->IDLE and busy=0 the following cycle.
//   Sweep takes exactly DEPTH cycles after rst deasserts.
//   IDLE: clr=1 -> CLEAR, clr_ptr=0, busy=1 from next cycle.
//  While busy: we_a/we_b ignored; clr ignored; dout_a=dout_b=0; collide stays 0.
//  rst mid-sweep: sweep restarts from address 0.
//  Writes (IDLE only): we_x=1 stores din_x at addr_x on posedge.
//   Ports are fully independent when addresses differ.
//  Collision: we_a & we_b & addr_a==addr_b -> store din_b if B_WINS else din_a.
//   collide=1 for exactly the next cycle.
//   Same address with only one write, or two reads: no collision.
//  READ_REG=0: dout_x = mem[addr_x] combinationally.
//   A write becomes visible on dout immediately after the writing edge.
//  READ_REG=1: dout_x <= mem[addr_x] each edge, read-first.
//   Same-edge write to the same address returns old data; new data one cycle later.
//   Cross-port read of an address written on the same edge also returns old data.
//  No address wrap issues: all ADDR_W values are valid; no out-of-range case.
// TESTING (DATA_W=8, ADDR_W=4)
//  1 Reset then idle: rst 1->0 -> busy=1 for 16 cycles then 0; read addr 0..15 on both ports -> 8'h00.
//  2 Basic write/read: A writes 8'hAA@2, B writes 8'h55@5, then A reads 5, B reads 2 -> 8'h55 / 8'hAA.
//    Async: visible right after the write edge; READ_REG=1: one cycle later.
//  3 Collision: A writes 8'h11, B writes 8'h22, both @7 -> mem[7]=8'h11 (B_WINS=0) or 8'h22 (B_WINS=1);
//    collide=1 one cycle.
//    Parallel writes 8'h11@7, 8'h22@8 -> both stored, collide=0.
//  4 Read-first (READ_REG=1): mem[3]=8'h0F; A writes 8'hF0@3 while B reads 3 -> B sees 8'h0F then 8'hF0.
//  5 Clear: fill all 16 words, pulse clr -> busy 16 cycles; writes during sweep dropped; all words read 8'h00.
//  6 Reset mid-sweep at cycle 5 -> busy restarts; full 16-cycle sweep from addr 0.

Source files
------------

// File: rtl/dual_port_ram_clr.sv
// dual_port_ram_clr: true dual-port RAM on a single clock with selectable
// async/registered read, a zero-fill clear sequencer that runs after reset or
// on request, and deterministic same-address write-collision resolution.
module dual_port_ram_clr #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int READ_REG = 0,
    parameter int B_WINS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              busy,
    output logic              collide
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam bit B_PRIO = (B_WINS != 0);
    localparam bit REG_RD = (READ_REG != 0);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a_q;
    logic [DATA_W-1:0] rd_b_q;
    logic              collide_q;
    logic              write_ok;
    logic              clash;
    logic              wr_a;
    logic              wr_b;

    // State register; reset always restarts the sweep from address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    // Next state: sweep ends after the last word is written; clr restarts it from IDLE
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_ptr == '1) state_next = IDLE;
            IDLE:    if (clr)           state_next = CLEAR;
            default:                    state_next = CLEAR;
        endcase
    end

    // FSM outputs: busy covers reset and the whole sweep
    always_comb begin
        busy     = (state == CLEAR);
        write_ok = (state == IDLE);
    end

    // Sweep pointer: advances only while clearing, parked at 0 otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  clr_ptr <= '0;
        else if (state == CLEAR)  clr_ptr <= clr_ptr + 1'b1;
        else                      clr_ptr <= '0;
    end

    // Write qualification: on a same-address double write only the winning port stores
    always_comb begin
        clash = write_ok & we_a & we_b & (addr_a == addr_b);
        wr_a  = write_ok & we_a & ~(clash & B_PRIO);
        wr_b  = write_ok & we_b & ~(clash & ~B_PRIO);
    end

    // Array update: the sweep owns the array while clearing, ports write when idle
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (wr_a) mem[addr_a] <= din_a;
            if (wr_b) mem[addr_b] <= din_b;
        end
    end

    // Registered read, read-first: samples the array before this edge's writes land
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else if (state == CLEAR) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= mem[addr_a];
            rd_b_q <= mem[addr_b];
        end
    end

    // Collision flag: one-cycle pulse following a same-address double write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) collide_q <= 1'b0;
        else     collide_q <= clash;
    end

    // Read data mux: forced to zero while busy so stale contents never leak out
    always_comb begin
        if (busy) begin
            dout_a = '0;
            dout_b = '0;
        end else if (REG_RD) begin
            dout_a = rd_a_q;
            dout_b = rd_b_q;
        end else begin
            dout_a = mem[addr_a];
            dout_b = mem[addr_b];
        end
        collide = collide_q;
    end

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Bench for dual_port_ram_clr: two instances share stimulus,
// u0 = async read / port A wins, u1 = registered read / port B wins.
module tb_dual_port_ram_clr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       we_a = 1'b0, we_b = 1'b0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic [7:0] din_a = '0, din_b = '0;
    logic [7:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic       busy0, busy1, collide0, collide1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dual_port_ram_clr #(.DATA_W(8), .ADDR_W(4), .READ_REG(0), .B_WINS(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr),
        .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0),
        .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0),
        .busy(busy0), .collide(collide0)
    );

    dual_port_ram_clr #(.DATA_W(8), .ADDR_W(4), .READ_REG(1), .B_WINS(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr),
        .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1),
        .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1),
        .busy(busy1), .collide(collide1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int cnt;
        rst = 1'b1;
        repeat (3) tick;
        n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL rst_busy0: got %b want 1", busy0); end
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL rst_busy1: got %b want 1", busy1); end
        n_cmp++; if (collide0 !== 1'b0) begin n_err++; $display("FAIL rst_collide0: got %b want 0", collide0); end
        n_cmp++; if (dout_a1 !== 8'h00) begin n_err++; $display("FAIL rst_dout_a1: got %h want 00", dout_a1); end
        n_cmp++; if (dout_b0 !== 8'h00) begin n_err++; $display("FAIL rst_dout_b0: got %h want 00", dout_b0); end
        rst = 1'b0;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            tick;
            cnt++;
        end
        n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL rst_sweep_len: got %0d want 16", cnt); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_busy1_end: got %b want 0", busy1); end
        for (int i = 0; i < 16; i++) begin
            addr_a = 4'(i);
            addr_b = 4'(15 - i);
            tick;
            n_cmp++; if (dout_a0 !== 8'h00 || dout_b0 !== 8'h00) begin n_err++; $display("FAIL rst_read0 @%0d: got %h/%h want 00/00", i, dout_a0, dout_b0); end
            n_cmp++; if (dout_a1 !== 8'h00 || dout_b1 !== 8'h00) begin n_err++; $display("FAIL rst_read1 @%0d: got %h/%h want 00/00", i, dout_a1, dout_b1); end
        end
    endtask

    task automatic test_basic;
        we_a = 1'b1; addr_a = 4'd2; din_a = 8'hAA;
        we_b = 1'b1; addr_b = 4'd5; din_b = 8'h55;
        tick;
        we_a = 1'b0; we_b = 1'b0;
        n_cmp++; if (dout_a0 !== 8'hAA) begin n_err++; $display("FAIL basic_async_a: got %h want AA", dout_a0); end
        n_cmp++; if (dout_b0 !== 8'h55) begin n_err++; $display("FAIL basic_async_b: got %h want 55", dout_b0); end
        n_cmp++; if (dout_a1 !== 8'h00) begin n_err++; $display("FAIL basic_reg_a_old: got %h want 00", dout_a1); end
        tick;
        n_cmp++; if (dout_a1 !== 8'hAA) begin n_err++; $display("FAIL basic_reg_a: got %h want AA", dout_a1); end
        n_cmp++; if (dout_b1 !== 8'h55) begin n_err++; $display("FAIL basic_reg_b: got %h want 55", dout_b1); end
        addr_a = 4'd5; addr_b = 4'd2;
        #1;
        n_cmp++; if (dout_a0 !== 8'h55 || dout_b0 !== 8'hAA) begin n_err++; $display("FAIL basic_cross0: got %h/%h want 55/AA", dout_a0, dout_b0); end
        tick;
        n_cmp++; if (dout_a1 !== 8'h55 || dout_b1 !== 8'hAA) begin n_err++; $display("FAIL basic_cross1: got %h/%h want 55/AA", dout_a1, dout_b1); end
        n_cmp++; if (collide0 !== 1'b0 || collide1 !== 1'b0) begin n_err++; $display("FAIL basic_collide: got %b/%b want 0/0", collide0, collide1); end
    endtask

    task automatic test_collision;
        we_a = 1'b1; addr_a = 4'd7; din_a = 8'h11;
        we_b = 1'b1; addr_b = 4'd7; din_b = 8'h22;
        tick;
        we_a = 1'b0; we_b = 1'b0;
        n_cmp++; if (collide0 !== 1'b1 || collide1 !== 1'b1) begin n_err++; $display("FAIL coll_flag: got %b/%b want 1/1", collide0, collide1); end
        n_cmp++; if (dout_a0 !== 8'h11 || dout_b0 !== 8'h11) begin n_err++; $display("FAIL coll_awins: got %h/%h want 11/11", dout_a0, dout_b0); end
        tick;
        n_cmp++; if (collide0 !== 1'b0 || collide1 !== 1'b0) begin n_err++; $display("FAIL coll_pulse_len: got %b/%b want 0/0", collide0, collide1); end
        n_cmp++; if (dout_a1 !== 8'h22 || dout_b1 !== 8'h22) begin n_err++; $display("FAIL coll_bwins: got %h/%h want 22/22", dout_a1, dout_b1); end
        we_a = 1'b1; addr_a = 4'd7; din_a = 8'h11;
        we_b = 1'b1; addr_b = 4'd8; din_b = 8'h22;
        tick;
        we_a = 1'b0; we_b = 1'b0;
        n_cmp++; if (collide0 !== 1'b0 || collide1 !== 1'b0) begin n_err++; $display("FAIL par_collide: got %b/%b want 0/0", collide0, collide1); end
        n_cmp++; if (dout_a0 !== 8'h11 || dout_b0 !== 8'h22) begin n_err++; $display("FAIL par_async: got %h/%h want 11/22", dout_a0, dout_b0); end
        tick;
        n_cmp++; if (dout_a1 !== 8'h11 || dout_b1 !== 8'h22) begin n_err++; $display("FAIL par_reg: got %h/%h want 11/22", dout_a1, dout_b1); end
        we_b = 1'b1; addr_a = 4'd8; addr_b = 4'd8; din_b = 8'h33;
        tick;
        we_b = 1'b0;
        n_cmp++; if (collide0 !== 1'b0 || collide1 !== 1'b0) begin n_err++; $display("FAIL single_wr_collide: got %b/%b want 0/0", collide0, collide1); end
    endtask

    task automatic test_read_first;
        we_a = 1'b1; addr_a = 4'd3; din_a = 8'h0F;
        tick;
        din_a = 8'hF0; addr_b = 4'd3;
        tick;
        we_a = 1'b0;
        n_cmp++; if (dout_b1 !== 8'h0F) begin n_err++; $display("FAIL rf_old: got %h want 0F", dout_b1); end
        n_cmp++; if (dout_a1 !== 8'h0F) begin n_err++; $display("FAIL rf_same_port_old: got %h want 0F", dout_a1); end
        n_cmp++; if (dout_b0 !== 8'hF0) begin n_err++; $display("FAIL rf_async_new: got %h want F0", dout_b0); end
        tick;
        n_cmp++; if (dout_b1 !== 8'hF0) begin n_err++; $display("FAIL rf_new: got %h want F0", dout_b1); end
    endtask

    task automatic test_clear;
        int cnt;
        for (int i = 0; i < 16; i++) begin
            we_a = 1'b1; addr_a = 4'(i); din_a = 8'(8'hC0 + i);
            tick;
        end
        we_a = 1'b0; addr_a = 4'd9;
        #1;
        n_cmp++; if (dout_a0 !== 8'hC9) begin n_err++; $display("FAIL clr_prefill: got %h want C9", dout_a0); end
        clr = 1'b1;
        tick;
        n_cmp++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin n_err++; $display("FAIL clr_busy: got %b/%b want 1/1", busy0, busy1); end
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            we_a = 1'b1; we_b = 1'b1; din_a = 8'hFF; din_b = 8'hEE;
            addr_a = 4'(cnt + 15); addr_b = 4'(cnt + 15);
            #1;
            n_cmp++; if (dout_a0 !== 8'h00 || dout_b0 !== 8'h00) begin n_err++; $display("FAIL clr_dout_gate @%0d: got %h/%h want 00/00", cnt, dout_a0, dout_b0); end
            n_cmp++; if (collide0 !== 1'b0 || collide1 !== 1'b0) begin n_err++; $display("FAIL clr_collide @%0d: got %b/%b want 0/0", cnt, collide0, collide1); end
            tick;
            cnt++;
        end
        clr = 1'b0; we_a = 1'b0; we_b = 1'b0;
        n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL clr_sweep_len: got %0d want 16", cnt); end
        for (int i = 0; i < 16; i++) begin
            addr_a = 4'(i); addr_b = 4'(i ^ 15);
            tick;
            n_cmp++; if (dout_a0 !== 8'h00 || dout_b0 !== 8'h00) begin n_err++; $display("FAIL clr_read0 @%0d: got %h/%h want 00/00", i, dout_a0, dout_b0); end
            n_cmp++; if (dout_a1 !== 8'h00 || dout_b1 !== 8'h00) begin n_err++; $display("FAIL clr_read1 @%0d: got %h/%h want 00/00", i, dout_a1, dout_b1); end
        end
    endtask

    task automatic test_reset_mid;
        int cnt;
        we_a = 1'b1; addr_a = 4'd0; din_a = 8'h77;
        we_b = 1'b1; addr_b = 4'd15; din_b = 8'hEE;
        tick;
        we_a = 1'b0; we_b = 1'b0;
        tick;
        n_cmp++; if (dout_a1 !== 8'h77) begin n_err++; $display("FAIL mid_prefill: got %h want 77", dout_a1); end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        #2;
        n_cmp++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin n_err++; $display("FAIL mid_rst_busy: got %b/%b want 1/1", busy0, busy1); end
        n_cmp++; if (collide1 !== 1'b0 || dout_a1 !== 8'h00) begin n_err++; $display("FAIL mid_rst_out: got %b/%h want 0/00", collide1, dout_a1); end
        rst = 1'b0;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            tick;
            cnt++;
        end
        n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL mid_sweep_len: got %0d want 16", cnt); end
        addr_a = 4'd0; addr_b = 4'd15;
        tick;
        n_cmp++; if (dout_a0 !== 8'h00 || dout_b0 !== 8'h00) begin n_err++; $display("FAIL mid_read0: got %h/%h want 00/00", dout_a0, dout_b0); end
        n_cmp++; if (dout_a1 !== 8'h00 || dout_b1 !== 8'h00) begin n_err++; $display("FAIL mid_read1: got %h/%h want 00/00", dout_a1, dout_b1); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_collision;
        test_read_first;
        test_clear;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
